pacman_mover: RTL

Player-side position controller for Pac-Man: turns buffered joystick requests into the `pacloc`/`pacfacing` words that the ghost AI blocks consume, one tile per movement tick. Legality of every step is checked through a request/response wall-lookup port shared with the maze ROM. After each committed move it emits a one-cycle `ghost_update` strobe so the ghosts recompute against the new position.

---
 rtl/pacman_mover_if.sv | 22 ++
 rtl/pacman_mover.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pacman_mover_if.sv
// Wall-lookup port shared between the Pac-Man mover (master) and the maze ROM
// responder (slave): one-cycle query, response some cycles later.
interface pacman_mover_if;
  logic        wall_qvalid;
  logic [15:0] wall_qloc;
  logic        wall_rvalid;
  logic        wall_hit;

  modport master (
    output wall_qvalid,
    output wall_qloc,
    input  wall_rvalid,
    input  wall_hit
  );

  modport slave (
    input  wall_qvalid,
    input  wall_qloc,
    output wall_rvalid,
    output wall_hit
  );
endinterface

// File: rtl/pacman_mover.sv
// Pac-Man position controller: buffers joystick turns, checks each step against
// the wall-lookup port, commits one tile per tick. Define PACMAN_TUNNEL_EN for side-tunnel wrap.
module pacman_mover #(
  parameter logic [15:0] START_LOC    = 16'h0E17,
  parameter logic [15:0] START_FACING = 16'h0100,
  parameter int unsigned MAZE_COLS    = 28,
  parameter logic [7:0]  TUNNEL_ROW   = 8'd14,
  parameter int unsigned RESP_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic           req_up,
  input  logic           req_down,
  input  logic           req_left,
  input  logic           req_right,
  pacman_mover_if.master wall,
  output logic [15:0]    pacloc,
  output logic [15:0]    pacfacing,
  output logic           ghost_update,
  output logic           stalled,
  output logic           busy
);

  localparam logic [15:0] DIR_LEFT  = 16'h0100;
  localparam logic [15:0] DIR_RIGHT = 16'hFF00;
  localparam logic [15:0] DIR_DOWN  = 16'h0001;
  localparam logic [15:0] DIR_UP    = 16'h00FF;

  localparam logic [7:0] COLS8    = 8'(MAZE_COLS);
  localparam logic [7:0] LAST_COL = 8'(MAZE_COLS - 1);

`ifdef PACMAN_TUNNEL_EN
  localparam bit TUNNEL_EN = 1'b1;
`else
  localparam bit TUNNEL_EN = 1'b0;
`endif

  localparam int TW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(RESP_TIMEOUT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] QREQ   = 3'd1;
  localparam logic [2:0] WREQ   = 3'd2;
  localparam logic [2:0] QFWD   = 3'd3;
  localparam logic [2:0] WFWD   = 3'd4;
  localparam logic [2:0] COMMIT = 3'd5;

  logic [2:0]    state;
  logic [15:0]   pending;
  logic [15:0]   move_dir;
  logic [15:0]   target_loc;
  logic          target_oob;
  logic [TW-1:0] wait_cnt;

  logic [15:0] req_dir;
  logic        req_any;
  logic [15:0] pending_next;
  logic        pending_live;
  logic [15:0] try_dir;
  logic [15:0] raw_loc;
  logic [15:0] tgt_loc;
  logic        tgt_oob;
  logic        q_state;
  logic        w_state;
  logic        resp_seen;
  logic        w_clear;
  logic        w_done;

  // Bytewise step: column and row wrap independently, no carry between them.
  function automatic logic [15:0] step(input logic [15:0] loc, input logic [15:0] dir);
    logic [7:0] col;
    logic [7:0] row;
    col = loc[15:8] + dir[15:8];
    row = loc[7:0] + dir[7:0];
    return {col, row};
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned -- an unassigned path would infer a latch.
  always_comb begin
    req_any = req_up | req_down | req_left | req_right;
    req_dir = 16'h0000;
    if (req_up)         req_dir = DIR_UP;
    else if (req_down)  req_dir = DIR_DOWN;
    else if (req_left)  req_dir = DIR_LEFT;
    else if (req_right) req_dir = DIR_RIGHT;
  end

  assign q_state      = (state == QREQ) || (state == QFWD);
  assign w_state      = (state == WREQ) || (state == WFWD);
  assign pending_live = (pending != 16'h0000) && (pending != pacfacing);
  assign try_dir      = (state == QREQ) ? pending : pacfacing;
  assign raw_loc      = step(pacloc, try_dir);

  // Off-maze columns are walls; on the tunnel row they wrap to the far side instead.
  always_comb begin
    tgt_loc = raw_loc;
    tgt_oob = (raw_loc[15:8] >= COLS8);
    if (TUNNEL_EN && (raw_loc[7:0] == TUNNEL_ROW)) begin
      if (raw_loc[15:8] == 8'hFF) begin
        tgt_loc = {LAST_COL, raw_loc[7:0]};
        tgt_oob = 1'b0;
      end else if (raw_loc[15:8] == COLS8) begin
        tgt_loc = {8'h00, raw_loc[7:0]};
        tgt_oob = 1'b0;
      end
    end
  end

  always_comb begin
    wall.wall_qvalid = q_state && !tgt_oob;
    wall.wall_qloc   = 16'h0000;
    if (q_state && !tgt_oob) wall.wall_qloc = tgt_loc;
  end

  // An out-of-range target resolves as a hit on its first wait cycle.
  assign resp_seen = w_state && wall.wall_rvalid && !target_oob;
  assign w_clear   = resp_seen && !wall.wall_hit;
  assign w_done    = w_state && (target_oob || resp_seen || (wait_cnt == WAIT_LAST));

  // Newest joystick request wins; a request matching the facing is redundant.
  always_comb begin
    pending_next = pending;
    if ((state == WREQ) && w_clear) pending_next = 16'h0000;
    if (req_any)                    pending_next = req_dir;
    if (pending_next == pacfacing)  pending_next = 16'h0000;
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values and simulation matches the synthesized registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pacloc       <= START_LOC;
      pacfacing    <= START_FACING;
      pending      <= 16'h0000;
      move_dir     <= START_FACING;
      target_loc   <= START_LOC;
      target_oob   <= 1'b0;
      wait_cnt     <= '0;
      ghost_update <= 1'b0;
      stalled      <= 1'b0;
    end else begin
      ghost_update <= 1'b0;
      pending      <= pending_next;

      case (state)
        IDLE: begin
          if (tick) state <= pending_live ? QREQ : QFWD;
        end

        QREQ, QFWD: begin
          move_dir   <= try_dir;
          target_loc <= tgt_loc;
          target_oob <= tgt_oob;
          wait_cnt   <= '0;
          state      <= (state == QREQ) ? WREQ : WFWD;
        end

        WREQ: begin
          if (w_done) state <= w_clear ? COMMIT : QFWD;
          else        wait_cnt <= wait_cnt + TW'(1);
        end

        WFWD: begin
          if (w_done) begin
            state <= w_clear ? COMMIT : IDLE;
            if (!w_clear) stalled <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end

        COMMIT: begin
          // Position and facing change together so ghosts never see a half-update.
          pacloc       <= target_loc;
          pacfacing    <= move_dir;
          stalled      <= 1'b0;
          ghost_update <= 1'b1;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
